inst_fetch_issuer: RTL and testbench
====================================

INST_FETCH_ISSUER -- requirements
Module: inst_fetch_issuer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, fetch address after reset.
REQ-002 SHALL have parameter MAX_INFLIGHT, default 2, max outstanding memory reads; legal values 1..2 (queue write margin is 2 slots).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc.
REQ-007 redirect_pc  input  32  new fetch address.
REQ-008 ireq_valid  output  1  memory read request valid.
REQ-009 ireq_ready  input  1  memory accepts request.
REQ-010 ireq_addr  output  32  read address, word aligned.
REQ-011 iresp_valid  input  1  read data valid; in order; cannot be back-pressured.
REQ-012 iresp_data  input  32  instruction word.
REQ-013 q_wready  input  1  instruction queue write ready (guarantees >=2 free slots).
REQ-014 q_wvalid  output  1  queue write strobe.
REQ-015 q_wdata  output  64  {pc[63:32], inst[31:0]}.
REQ-016 q_kill  output  1  queue flush, driven equal to redirect_valid.

Function
REQ-017 SHALL hold fetch pc register; ireq_addr = pc.
REQ-018 ireq_valid SHALL be 1 iff inflight < MAX_INFLIGHT, q_wready=1, redirect_valid=0.
REQ-019 On ireq_valid&&ireq_ready: pc <= pc+4 (mod 2^32), pc pushed to 2-entry pc FIFO, inflight += 1.
REQ-020 On iresp_valid: pc FIFO popped, inflight -= 1; same-cycle accept and response leave inflight unchanged.
REQ-021 If drop_cnt=0 and redirect_valid=0, iresp_valid SHALL drive q_wvalid=1 combinationally that cycle, q_wdata={FIFO head pc, iresp_data}; zero latency.
REQ-022 If drop_cnt>0, response SHALL be discarded (q_wvalid=0), drop_cnt -= 1.
REQ-023 On redirect_valid: pc <= redirect_pc, q_kill=1, q_wvalid=0, drop_cnt <= inflight minus 1 if a response arrives that cycle (that response is also discarded).
REQ-024 Redirect while drop_cnt>0 SHALL recompute drop_cnt per REQ-023 (all older in-flight dropped).
REQ-025 New requests after redirect SHALL issue the following cycle even with drops pending; inflight counts dropped entries.
REQ-026 iresp_valid with inflight=0 is illegal; simulation assertion SHALL fire.
REQ-027 redirect_pc[1:0]!=0 is illegal; assertion SHALL fire.
REQ-028 q_wvalid SHALL never be 1 while q_wready was 0 at issue of that entry (guaranteed by REQ-018).

Reset
REQ-029 On reset: pc=RESET_PC, inflight=0, drop_cnt=0, pc FIFO empty; ireq_valid, q_wvalid, q_kill = 0 while reset is high.
REQ-030 Reset mid-transaction SHALL abandon outstanding reads; memory side is reset together.
REQ-031 First request MAY assert in first cycle after reset deasserts.

Structure
REQ-032 Shared package SHALL hold XLEN=32, INST_LEN=32 and the {pc,inst} queue-entry packed type (64 bits).
REQ-033 pc FIFO SHALL be one sub-module, pc_track_fifo (depth 2, push/pop, no backpressure).
REQ-034 Target size 120-400 RTL lines; no other sub-modules.

Verification
REQ-035 Reset release, ireq_ready=1, 1-cycle memory -> addrs 0,4,8 issued; queue gets {0,i0},{4,i1},{8,i2} in order.
REQ-036 q_wready=0 held 5 cycles -> ireq_valid=0 those cycles; resumes at correct pc next cycle after q_wready=1.
REQ-037 Two requests (0,4) outstanding, redirect to 0x100 -> q_kill=1 one cycle, both responses dropped, next queue entry {0x100, inst}.
REQ-038 Redirect same cycle as response of last in-flight -> that response dropped, drop_cnt=0, no stray write.
REQ-039 Second redirect to 0x200 while drop_cnt=1 -> all older dropped, first write {0x200, inst}.
REQ-040 pc=0xFFFF_FFFC accepted -> next ireq_addr=0x0000_0000 (wrap).

Source files
------------

// File: rtl/inst_fetch_issuer_pkg.sv
// Shared widths and the instruction-queue entry layout for the fetch issuer.
package inst_fetch_issuer_pkg;

    localparam int XLEN     = 32;
    localparam int INST_LEN = 32;

    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [INST_LEN-1:0] inst;
    } q_entry_t;

endpackage

// File: rtl/inst_fetch_issuer_pc_track_fifo.sv
// Two-entry FIFO of issued fetch addresses, popped in order as read responses return.
module pc_track_fifo
    import inst_fetch_issuer_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic [XLEN-1:0] push_pc,
    input  logic            pop,
    output logic [XLEN-1:0] head_pc
);

    logic [XLEN-1:0] slots [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // NOTE: storage is not reset; the count and pointers alone decide which slots hold live data.
    always_ff @(posedge clk) begin
        if (push) slots[wr_ptr] <= push_pc;
    end

    assign head_pc = slots[rd_ptr];

    // The issuer's in-flight cap keeps the FIFO from over- or under-flowing.
    assert property (@(posedge clk) disable iff (reset) push |-> (count != 2'd2));
    assert property (@(posedge clk) disable iff (reset) pop  |-> (count != 2'd0));

endmodule

// File: rtl/inst_fetch_issuer.sv
// Instruction fetch issuer: issues word reads, pairs in-order responses with their pc,
// and forwards them to the instruction queue, discarding responses made stale by a redirect.
module inst_fetch_issuer
    import inst_fetch_issuer_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
    parameter int              MAX_INFLIGHT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     ireq_valid,
    input  logic                     ireq_ready,
    output logic [XLEN-1:0]          ireq_addr,
    input  logic                     iresp_valid,
    input  logic [INST_LEN-1:0]      iresp_data,
    input  logic                     q_wready,
    output logic                     q_wvalid,
    output logic [XLEN+INST_LEN-1:0] q_wdata,
    output logic                     q_kill
);

    localparam logic [1:0] MAX_INF = 2'(MAX_INFLIGHT);

    logic [XLEN-1:0] pc;
    logic [1:0]      inflight;
    logic [1:0]      inflight_next;
    logic [1:0]      drop_cnt;
    logic [1:0]      drop_next;
    logic            accept;
    logic [XLEN-1:0] head_pc;
    q_entry_t        entry;

    assign ireq_addr  = pc;
    assign ireq_valid = !reset && (inflight < MAX_INF) && q_wready && !redirect_valid;
    assign accept     = ireq_valid && ireq_ready;
    assign q_kill     = !reset && redirect_valid;
    assign q_wvalid   = !reset && iresp_valid && (drop_cnt == 2'd0) && !redirect_valid;

    assign entry.pc   = head_pc;
    assign entry.inst = iresp_data;
    assign q_wdata    = entry;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        inflight_next = inflight;
        drop_next     = drop_cnt;

        if (accept && !iresp_valid)
            inflight_next = inflight + 2'd1;
        else if (!accept && iresp_valid)
            inflight_next = inflight - 2'd1;

        // A redirect condemns everything still outstanding, including a response arriving now.
        if (redirect_valid)
            drop_next = iresp_valid ? inflight - 2'd1 : inflight;
        else if (iresp_valid && (drop_cnt != 2'd0))
            drop_next = drop_cnt - 2'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            inflight <= 2'd0;
            drop_cnt <= 2'd0;
        end else begin
            inflight <= inflight_next;
            drop_cnt <= drop_next;
            if (redirect_valid)
                pc <= redirect_pc;
            else if (accept)
                pc <= pc + 32'd4;
        end
    end

    pc_track_fifo u_pc_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (accept),
        .push_pc (pc),
        .pop     (iresp_valid),
        .head_pc (head_pc)
    );

    assert property (@(posedge clk) disable iff (reset) iresp_valid |-> (inflight != 2'd0));
    assert property (@(posedge clk) disable iff (reset) redirect_valid |-> (redirect_pc[1:0] == 2'b00));

endmodule

// File: tb/tb_inst_fetch_issuer.sv
// Directed bench for inst_fetch_issuer: a 1-cycle memory model plus a queue-write scoreboard.
module tb_inst_fetch_issuer;
    import inst_fetch_issuer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ireq_valid;
    logic        ireq_ready;
    logic [31:0] ireq_addr;
    logic        iresp_valid;
    logic [31:0] iresp_data;
    logic        q_wready;
    logic        q_wvalid;
    logic [63:0] q_wdata;
    logic        q_kill;
    logic        mem_hold;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q [$];
    logic [31:0] pend  [$];

    inst_fetch_issuer #(.RESET_PC(32'h0000_0000), .MAX_INFLIGHT(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ireq_valid     (ireq_valid),
        .ireq_ready     (ireq_ready),
        .ireq_addr      (ireq_addr),
        .iresp_valid    (iresp_valid),
        .iresp_data     (iresp_data),
        .q_wready       (q_wready),
        .q_wvalid       (q_wvalid),
        .q_wdata        (q_wdata),
        .q_kill         (q_kill)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_push(input logic [31:0] a);
        exp_q.push_back({a, inst_of(a)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory: requests seen at the falling edge are answered in the cycle after acceptance.
    always @(negedge clk)
        if (!reset && ireq_valid && ireq_ready) pend.push_back(ireq_addr);

    initial begin
        logic [31:0] a;
        iresp_valid = 1'b0;
        iresp_data  = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                pend.delete();
                iresp_valid = 1'b0;
            end else if (!mem_hold && pend.size() > 0) begin
                a = pend.pop_front();
                iresp_valid = 1'b1;
                iresp_data  = inst_of(a);
            end else begin
                iresp_valid = 1'b0;
            end
        end
    end

    // Scoreboard monitor for queue writes.
    always @(negedge clk) begin
        if (!reset && q_wvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_qwrite: got %h expected no write", q_wdata);
            end else begin
                check("qwrite", q_wdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        ireq_ready = 1'b1; q_wready = 1'b1; mem_hold = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ireq_valid", ireq_valid, 0);
        check("rst_q_wvalid", q_wvalid, 0);
        check("rst_q_kill", q_kill, 0);
        check("rst_addr", ireq_addr, 32'h0);
        tick();
        reset = 1'b0;

        // Streaming fetch 0,4,8
        for (int i = 0; i < 3; i++) begin
            exp_push(32'(4 * i));
            @(negedge clk);
            check("stream_valid", ireq_valid, 1);
            check("stream_addr", ireq_addr, 64'(4 * i));
            tick();
        end
        q_wready = 1'b0;

        // Queue back-pressure for 5 cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_ireq_valid", ireq_valid, 0);
            tick();
        end
        q_wready = 1'b1;
        exp_push(32'hC);
        @(negedge clk);
        check("bp_resume_valid", ireq_valid, 1);
        check("bp_resume_addr", ireq_addr, 32'hC);
        tick();
        q_wready = 1'b0;
        tick();
        tick();

        // Two outstanding (0,4) then redirect to 0x100
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        @(negedge clk);
        check("rd0_kill", q_kill, 1);
        check("rd0_ireq_valid", ireq_valid, 0);
        tick();
        redirect_valid = 1'b0; q_wready = 1'b1; mem_hold = 1'b1;
        @(negedge clk);
        check("out_addr0", ireq_addr, 32'h0);
        check("out_valid0", ireq_valid, 1);
        tick();
        @(negedge clk);
        check("out_addr4", ireq_addr, 32'h4);
        check("out_valid4", ireq_valid, 1);
        tick();
        @(negedge clk);
        check("inflight_cap", ireq_valid, 0);
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        check("rd100_kill", q_kill, 1);
        check("rd100_ireq_valid", ireq_valid, 0);
        tick();
        redirect_valid = 1'b0; mem_hold = 1'b0;
        @(negedge clk);
        check("rd100_kill_once", q_kill, 0);
        check("rd100_drop0", q_wvalid, 0);
        tick();
        exp_push(32'h100);
        @(negedge clk);
        check("rd100_drop4", q_wvalid, 0);
        check("rd100_issue_valid", ireq_valid, 1);
        check("rd100_issue_addr", ireq_addr, 32'h100);
        tick();
        q_wready = 1'b0;
        tick();

        // Redirect coincides with response of the last in-flight read
        q_wready = 1'b1;
        @(negedge clk);
        check("same_issue_addr", ireq_addr, 32'h104);
        tick();
        q_wready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300;
        @(negedge clk);
        check("same_kill", q_kill, 1);
        check("same_drop", q_wvalid, 0);
        tick();
        redirect_valid = 1'b0; q_wready = 1'b1;
        exp_push(32'h300);
        @(negedge clk);
        check("same_next_addr", ireq_addr, 32'h300);
        check("same_next_valid", ireq_valid, 1);
        tick();
        q_wready = 1'b0;
        tick();

        // Second redirect while a drop is still pending
        mem_hold = 1'b1; q_wready = 1'b1;
        @(negedge clk);
        check("dbl_addr304", ireq_addr, 32'h304);
        tick();
        @(negedge clk);
        check("dbl_addr308", ireq_addr, 32'h308);
        tick();
        q_wready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h400;
        @(negedge clk);
        check("dbl_kill1", q_kill, 1);
        tick();
        redirect_valid = 1'b0; mem_hold = 1'b0;
        @(negedge clk);
        check("dbl_drop304", q_wvalid, 0);
        tick();
        mem_hold = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        check("dbl_kill2", q_kill, 1);
        tick();
        redirect_valid = 1'b0; mem_hold = 1'b0; q_wready = 1'b1;
        exp_push(32'h200);
        @(negedge clk);
        check("dbl_drop308", q_wvalid, 0);
        check("dbl_issue_valid", ireq_valid, 1);
        check("dbl_issue_addr", ireq_addr, 32'h200);
        tick();
        q_wready = 1'b0;
        tick();

        // Address wrap at the top of the space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        check("wrap_kill", q_kill, 1);
        tick();
        redirect_valid = 1'b0; q_wready = 1'b1;
        exp_push(32'hFFFF_FFFC);
        @(negedge clk);
        check("wrap_addr_top", ireq_addr, 32'hFFFF_FFFC);
        tick();
        exp_push(32'h0);
        @(negedge clk);
        check("wrap_valid", ireq_valid, 1);
        check("wrap_addr_zero", ireq_addr, 32'h0);
        tick();
        q_wready = 1'b0;
        tick();
        tick();

        // Reset while a read is outstanding
        mem_hold = 1'b1; q_wready = 1'b1;
        @(negedge clk);
        check("mid_addr", ireq_addr, 32'h4);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", ireq_valid, 0);
        check("mid_rst_qwvalid", q_wvalid, 0);
        check("mid_rst_addr", ireq_addr, 32'h0);
        tick();
        reset = 1'b0; mem_hold = 1'b0;
        exp_push(32'h0);
        @(negedge clk);
        check("mid_restart_valid", ireq_valid, 1);
        check("mid_restart_addr", ireq_addr, 32'h0);
        tick();
        q_wready = 1'b0;
        repeat (4) tick();

        check("sb_drained", 64'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
